// File: rtl/vx_pending_tracker_pkg.sv
// ---------------------------------------------------------------------------
// vx_pending_tracker_pkg
//   Shared types and sizing helpers for the pending-instruction tracker.
//   - fence_state_e : per-warp fence FSM state (IDLE / WAIT)
//   - pcnt_width()  : width of the per-warp popcount of issue/commit strobes,
//                     wide enough for the larger port count plus a sign bit
//                     so the increment/decrement delta can be formed signed.
// ---------------------------------------------------------------------------
package vx_pending_tracker_pkg;

  typedef enum logic {
    FENCE_IDLE = 1'b0,
    FENCE_WAIT = 1'b1
  } fence_state_e;

  function automatic int pcnt_width(input int incr_cnt, input int decr_cnt);
    int m;
    m = (incr_cnt > decr_cnt) ? incr_cnt : decr_cnt;
    return $clog2(m + 1) + 1;
  endfunction

  // Popcount width for the default 1 issue / 2 commit port configuration.
  localparam int PCNT_W_DEF = pcnt_width(1, 2);

endpackage

// File: rtl/vx_pending_tracker_ctr.sv
// ---------------------------------------------------------------------------
// vx_pending_tracker_ctr
//   One per-warp pending counter with saturation and registered flags.
//   Ports:
//     clk, reset    : clock, synchronous active-low reset
//     i_inc, i_dec  : number of issue / commit strobes hitting this warp
//     i_thresh_n    : almost-empty threshold that applies from next cycle
//     o_zero        : counter == 0          (registered, tracks counter)
//     o_alm         : counter == threshold  (registered, tracks counter)
//     o_ovf, o_unf  : sticky saturation / clamp indicators
// ---------------------------------------------------------------------------
module vx_pending_tracker_ctr
  import vx_pending_tracker_pkg::*;
#(
  parameter int CTR_WIDTH     = 12,
  parameter int DW            = PCNT_W_DEF,
  parameter int ALM_EMPTY_DEF = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        i_inc,
  input  logic [DW-1:0]        i_dec,
  input  logic [CTR_WIDTH-1:0] i_thresh_n,
  output logic                 o_zero,
  output logic                 o_alm,
  output logic                 o_ovf,
  output logic                 o_unf
);

  // Two guard bits: one for overshoot above max, one for sign.
  localparam int SW = CTR_WIDTH + 2;
  localparam logic signed [SW-1:0] MAX_S = {2'b00, {CTR_WIDTH{1'b1}}};

  logic signed [DW-1:0]    w_delta;
  logic signed [SW-1:0]    w_cnt_n;
  logic [CTR_WIDTH-1:0]    w_cnt_sat;
  logic                    w_ovf_hit;
  logic                    w_unf_hit;

  logic [CTR_WIDTH-1:0]    r_cnt;
  logic                    r_zero;
  logic                    r_alm;
  logic                    r_ovf;
  logic                    r_unf;

  // NOTE: every signal written here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    w_delta   = $signed(i_inc) - $signed(i_dec);
    w_cnt_n   = $signed({2'b00, r_cnt}) + {{(SW-DW){w_delta[DW-1]}}, w_delta};
    w_ovf_hit = (w_cnt_n > MAX_S);
    w_unf_hit = w_cnt_n[SW-1];
    if (w_ovf_hit) begin
      w_cnt_sat = {CTR_WIDTH{1'b1}};
    end else if (w_unf_hit) begin
      w_cnt_sat = '0;
    end else begin
      w_cnt_sat = w_cnt_n[CTR_WIDTH-1:0];
    end
  end

  // Flags are computed from the next count so they change in the same cycle
  // as the counter itself rather than one cycle behind it.
  // NOTE: non-blocking assignments keep every register sampling pre-edge
  // values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
      r_alm  <= (ALM_EMPTY_DEF == 0);
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_sat;
      r_zero <= (w_cnt_sat == '0);
      r_alm  <= (w_cnt_sat == i_thresh_n);
      r_ovf  <= r_ovf | w_ovf_hit;
      r_unf  <= r_unf | w_unf_hit;
    end
  end

  assign o_zero = r_zero;
  assign o_alm  = r_alm;
  assign o_ovf  = r_ovf;
  assign o_unf  = r_unf;

endmodule

// File: rtl/vx_pending_tracker.sv
// ---------------------------------------------------------------------------
// vx_pending_tracker
//   Tracks in-flight instructions per warp and services per-warp fences.
//   Ports:
//     clk, reset          : clock, synchronous active-low reset
//     incr / incr_wid     : issue strobes and their warp ids
//     decr / decr_wid     : commit strobes and their warp ids
//     alm_thresh_we/_thresh: almost-empty threshold load
//     alm_empty_wid       : warp whose almost-empty flag drives alm_empty
//     fence_valid/_wid    : fence request, accepted when fence_ready
//     fence_done/_wid     : one-cycle completion pulse and its warp
//     empty, empty_mask   : all-zero / per-warp-zero status
//     alm_empty           : selected warp count equals threshold
//     overflow, underflow : sticky saturation / clamp indicators
// ---------------------------------------------------------------------------
module vx_pending_tracker
  import vx_pending_tracker_pkg::*;
#(
  parameter int CTR_WIDTH      = 12,
  parameter int WARP_CNT       = 4,
  parameter int WARP_CNT_WIDTH = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
  parameter int INCR_COUNT     = 1,
  parameter int DECR_COUNT     = 2,
  parameter int ALM_EMPTY_DEF  = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [INCR_COUNT-1:0]                      incr,
  input  logic [INCR_COUNT-1:0][WARP_CNT_WIDTH-1:0]  incr_wid,
  input  logic [DECR_COUNT-1:0]                      decr,
  input  logic [DECR_COUNT-1:0][WARP_CNT_WIDTH-1:0]  decr_wid,
  input  logic                                       alm_thresh_we,
  input  logic [CTR_WIDTH-1:0]                       alm_thresh,
  input  logic [WARP_CNT_WIDTH-1:0]                  alm_empty_wid,
  input  logic                                       fence_valid,
  input  logic [WARP_CNT_WIDTH-1:0]                  fence_wid,
  output logic                                       fence_ready,
  output logic                                       fence_done,
  output logic [WARP_CNT_WIDTH-1:0]                  fence_done_wid,
  output logic                                       empty,
  output logic [WARP_CNT-1:0]                        empty_mask,
  output logic                                       alm_empty,
  output logic                                       overflow,
  output logic                                       underflow
);

  localparam int DW = pcnt_width(INCR_COUNT, DECR_COUNT);

  logic [DW-1:0]              w_inc [WARP_CNT];
  logic [DW-1:0]              w_dec [WARP_CNT];
  logic [WARP_CNT-1:0]        w_incr_hit;
  logic [WARP_CNT-1:0]        w_zero;
  logic [WARP_CNT-1:0]        w_alm;
  logic [WARP_CNT-1:0]        w_ovf;
  logic [WARP_CNT-1:0]        w_unf;
  logic [CTR_WIDTH-1:0]       w_thresh_n;

  logic [WARP_CNT-1:0]        w_elig;
  logic                       w_grant_valid;
  logic [WARP_CNT_WIDTH-1:0]  w_grant_wid;
  fence_state_e               w_fstate_n [WARP_CNT];

  logic [CTR_WIDTH-1:0]       r_thresh;
  fence_state_e               r_fstate [WARP_CNT];
  logic                       r_fence_done;
  logic [WARP_CNT_WIDTH-1:0]  r_fence_done_wid;

  // Per-warp popcount of strobes addressed to that warp.
  always_comb begin
    for (int w = 0; w < WARP_CNT; w++) begin
      w_inc[w] = '0;
      w_dec[w] = '0;
      for (int p = 0; p < INCR_COUNT; p++) begin
        if (incr[p] && (incr_wid[p] == WARP_CNT_WIDTH'(w))) begin
          w_inc[w] = w_inc[w] + DW'(1);
        end
      end
      for (int p = 0; p < DECR_COUNT; p++) begin
        if (decr[p] && (decr_wid[p] == WARP_CNT_WIDTH'(w))) begin
          w_dec[w] = w_dec[w] + DW'(1);
        end
      end
      w_incr_hit[w] = (w_inc[w] != '0);
    end
  end

  // The counters compare against the threshold that will be live next
  // cycle, so a threshold write takes effect together with the new count.
  assign w_thresh_n = alm_thresh_we ? alm_thresh : r_thresh;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_thresh <= CTR_WIDTH'(ALM_EMPTY_DEF);
    end else begin
      r_thresh <= w_thresh_n;
    end
  end

  for (genvar g = 0; g < WARP_CNT; g++) begin : g_ctr
    vx_pending_tracker_ctr #(
      .CTR_WIDTH     (CTR_WIDTH),
      .DW            (DW),
      .ALM_EMPTY_DEF (ALM_EMPTY_DEF)
    ) u_ctr (
      .clk        (clk),
      .reset      (reset),
      .i_inc      (w_inc[g]),
      .i_dec      (w_dec[g]),
      .i_thresh_n (w_thresh_n),
      .o_zero     (w_zero[g]),
      .o_alm      (w_alm[g]),
      .o_ovf      (w_ovf[g]),
      .o_unf      (w_unf[g])
    );
  end

  // A fence may not be accepted by a warp that still holds one; the request
  // simply waits on the bus until that warp completes.
  assign fence_ready = (r_fstate[fence_wid] == FENCE_IDLE);

  // Fence next-state and fixed-priority completion grant (lowest wid wins).
  // An issue to a waiting warp in this cycle vetoes its completion, since the
  // registered empty flag does not yet reflect that issue.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_wid   = '0;
    for (int w = 0; w < WARP_CNT; w++) begin
      w_fstate_n[w] = r_fstate[w];
      w_elig[w]     = (r_fstate[w] == FENCE_WAIT) && w_zero[w] && !w_incr_hit[w];
    end
    for (int w = 0; w < WARP_CNT; w++) begin
      if (w_elig[w] && !w_grant_valid) begin
        w_grant_valid = 1'b1;
        w_grant_wid   = WARP_CNT_WIDTH'(w);
      end
    end
    if (w_grant_valid) begin
      w_fstate_n[w_grant_wid] = FENCE_IDLE;
    end
    if (fence_valid && fence_ready) begin
      w_fstate_n[fence_wid] = FENCE_WAIT;
    end
  end

  // Reset clears every waiting fence and the done pulse, so nothing pending
  // before reset ever completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < WARP_CNT; w++) begin
        r_fstate[w] <= FENCE_IDLE;
      end
      r_fence_done     <= 1'b0;
      r_fence_done_wid <= '0;
    end else begin
      for (int w = 0; w < WARP_CNT; w++) begin
        r_fstate[w] <= w_fstate_n[w];
      end
      r_fence_done     <= w_grant_valid;
      r_fence_done_wid <= w_grant_wid;
    end
  end

  assign fence_done     = r_fence_done;
  assign fence_done_wid = r_fence_done_wid;
  assign empty_mask     = w_zero;
  assign empty          = &w_zero;
  assign alm_empty      = w_alm[alm_empty_wid];
  assign overflow       = |w_ovf;
  assign underflow      = |w_unf;

endmodule

// File: tb/tb_vx_pending_tracker.sv
// ---------------------------------------------------------------------------
// tb_vx_pending_tracker
//   Directed scenarios plus a randomized run against a behavioural model of
//   per-warp counts, threshold, sticky flags and pending fences.
// ---------------------------------------------------------------------------
module tb_vx_pending_tracker;

  localparam int CW   = 4;
  localparam int WN   = 4;
  localparam int WW   = 2;
  localparam int IC   = 1;
  localparam int DC   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [IC-1:0]         incr;
  logic [IC-1:0][WW-1:0] incr_wid;
  logic [DC-1:0]         decr;
  logic [DC-1:0][WW-1:0] decr_wid;
  logic                  alm_thresh_we;
  logic [CW-1:0]         alm_thresh;
  logic [WW-1:0]         alm_empty_wid;
  logic                  fence_valid;
  logic [WW-1:0]         fence_wid;
  logic                  fence_ready;
  logic                  fence_done;
  logic [WW-1:0]         fence_done_wid;
  logic                  empty;
  logic [WN-1:0]         empty_mask;
  logic                  alm_empty;
  logic                  overflow;
  logic                  underflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  int          m_cnt [WN];
  int          m_thresh;
  bit          m_ovf, m_unf;
  bit          m_pend [WN];
  bit          m_done;
  logic [WW-1:0] m_done_wid;

  vx_pending_tracker #(
    .CTR_WIDTH      (CW),
    .WARP_CNT       (WN),
    .WARP_CNT_WIDTH (WW),
    .INCR_COUNT     (IC),
    .DECR_COUNT     (DC),
    .ALM_EMPTY_DEF  (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .incr           (incr),
    .incr_wid       (incr_wid),
    .decr           (decr),
    .decr_wid       (decr_wid),
    .alm_thresh_we  (alm_thresh_we),
    .alm_thresh     (alm_thresh),
    .alm_empty_wid  (alm_empty_wid),
    .fence_valid    (fence_valid),
    .fence_wid      (fence_wid),
    .fence_ready    (fence_ready),
    .fence_done     (fence_done),
    .fence_done_wid (fence_done_wid),
    .empty          (empty),
    .empty_mask     (empty_mask),
    .alm_empty      (alm_empty),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  // Apply one clock edge to the model using the inputs the DUT sees.
  task automatic model_edge();
    int  old_cnt [WN];
    bit  old_pend [WN];
    bit  hit [WN];
    int  inc, dec, n;
    bit  g;
    if (reset !== 1'b1) begin
      for (int w = 0; w < WN; w++) begin
        m_cnt[w]  = 0;
        m_pend[w] = 0;
      end
      m_thresh = 1;
      m_ovf    = 0;
      m_unf    = 0;
      m_done   = 0;
      return;
    end
    for (int w = 0; w < WN; w++) begin
      old_cnt[w]  = m_cnt[w];
      old_pend[w] = m_pend[w];
      inc = 0;
      dec = 0;
      for (int p = 0; p < IC; p++) if (incr[p] && incr_wid[p] == w) inc++;
      for (int p = 0; p < DC; p++) if (decr[p] && decr_wid[p] == w) dec++;
      hit[w] = (inc > 0);
      n = m_cnt[w] + inc - dec;
      if (n > MAXC) begin n = MAXC; m_ovf = 1; end
      if (n < 0)    begin n = 0;    m_unf = 1; end
      m_cnt[w] = n;
    end
    g = 0;
    for (int w = 0; w < WN; w++) begin
      if (!g && old_pend[w] && old_cnt[w] == 0 && !hit[w]) begin
        g = 1;
        m_done_wid = WW'(w);
      end
    end
    m_done = g;
    if (g) m_pend[m_done_wid] = 0;
    if (fence_valid && !old_pend[fence_wid]) m_pend[fence_wid] = 1;
    if (alm_thresh_we) m_thresh = alm_thresh;
  endtask

  function automatic logic [WN-1:0] exp_mask();
    logic [WN-1:0] r;
    for (int w = 0; w < WN; w++) r[w] = (m_cnt[w] == 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    incr          = '0;
    incr_wid      = '0;
    decr          = '0;
    decr_wid      = '0;
    alm_thresh_we = 1'b0;
    alm_thresh    = '0;
    fence_valid   = 1'b0;
    fence_wid     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    alm_empty_wid = 2'd0;
    reset = 1'b0;
    // Strobes during reset must be ignored.
    incr = 1'b1; incr_wid[0] = 2'd2;
    decr = 2'b11; decr_wid[0] = 2'd1; decr_wid[1] = 2'd3;
    fence_valid = 1'b1; fence_wid = 2'd1;
    tick();
    tick();
    n_cmp++; if (empty_mask !== 4'hF) begin n_fail++; $display("FAIL reset_mask: got %b want 1111", empty_mask); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got ovf=%b unf=%b want 0/0", overflow, underflow); end
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", fence_done); end
    n_cmp++; if (alm_empty !== 1'b0) begin n_fail++; $display("FAIL reset_alm: got %b want 0", alm_empty); end
    n_cmp++; if (fence_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", fence_ready); end
    clear_inputs();
    reset = 1'b1;
    tick();
    n_cmp++; if (empty_mask !== 4'hF) begin n_fail++; $display("FAIL reset_release_mask: got %b want 1111", empty_mask); end
  endtask

  task automatic test_count();
    do_reset();
    alm_empty_wid = 2'd2;
    incr = 1'b1; incr_wid[0] = 2'd2;
    repeat (3) tick();
    clear_inputs();
    n_cmp++; if (empty_mask !== 4'b1011) begin n_fail++; $display("FAIL count_mask3: got %b want 1011", empty_mask); end
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL count_empty3: got %b want 0", empty); end
    decr = 2'b11; decr_wid[0] = 2'd2; decr_wid[1] = 2'd2;
    tick();
    clear_inputs();
    n_cmp++; if (empty_mask !== 4'b1011) begin n_fail++; $display("FAIL count_mask1: got %b want 1011", empty_mask); end
    n_cmp++; if (alm_empty !== 1'b1) begin n_fail++; $display("FAIL count_alm1: got %b want 1", alm_empty); end
    decr = 2'b10; decr_wid[1] = 2'd2;
    tick();
    clear_inputs();
    n_cmp++; if (empty !== 1'b1 || empty_mask !== 4'hF) begin n_fail++; $display("FAIL count_drain: got empty=%b mask=%b want 1/1111", empty, empty_mask); end
    // Simultaneous issue and commit at zero nets to zero with no underflow.
    incr = 1'b1; incr_wid[0] = 2'd2; decr = 2'b01; decr_wid[0] = 2'd2;
    tick();
    clear_inputs();
    n_cmp++; if (empty_mask[2] !== 1'b1 || underflow !== 1'b0) begin n_fail++; $display("FAIL count_net0: got mask2=%b unf=%b want 1/0", empty_mask[2], underflow); end
  endtask

  task automatic test_alm();
    do_reset();
    alm_empty_wid = 2'd1;
    incr = 1'b1; incr_wid[0] = 2'd1;
    tick(); tick();
    clear_inputs();
    n_cmp++; if (alm_empty !== 1'b0) begin n_fail++; $display("FAIL alm_cnt2: got %b want 0", alm_empty); end
    decr = 2'b01; decr_wid[0] = 2'd1;
    tick();
    clear_inputs();
    n_cmp++; if (alm_empty !== 1'b1) begin n_fail++; $display("FAIL alm_cnt1: got %b want 1", alm_empty); end
    alm_thresh_we = 1'b1; alm_thresh = 4'd0;
    tick();
    clear_inputs();
    n_cmp++; if (alm_empty !== 1'b0) begin n_fail++; $display("FAIL alm_thresh0_cnt1: got %b want 0", alm_empty); end
    tick();
    n_cmp++; if (alm_empty !== 1'b0) begin n_fail++; $display("FAIL alm_thresh0_hold: got %b want 0", alm_empty); end
    decr = 2'b10; decr_wid[1] = 2'd1;
    tick();
    clear_inputs();
    n_cmp++; if (alm_empty !== 1'b1) begin n_fail++; $display("FAIL alm_thresh0_cnt0: got %b want 1", alm_empty); end
  endtask

  task automatic test_saturate();
    do_reset();
    alm_empty_wid = 2'd0;
    incr = 1'b1; incr_wid[0] = 2'd0;
    repeat (MAXC) tick();
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_at_max: got ovf=%b want 0", overflow); end
    tick();
    clear_inputs();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", overflow); end
    alm_thresh_we = 1'b1; alm_thresh = 4'(MAXC);
    tick();
    clear_inputs();
    n_cmp++; if (alm_empty !== 1'b1) begin n_fail++; $display("FAIL sat_value_max: got alm=%b want 1", alm_empty); end
    decr = 2'b01; decr_wid[0] = 2'd3;
    tick();
    clear_inputs();
    n_cmp++; if (underflow !== 1'b1 || empty_mask[3] !== 1'b1) begin n_fail++; $display("FAIL sat_unf: got unf=%b mask3=%b want 1/1", underflow, empty_mask[3]); end
    decr = 2'b11; decr_wid[0] = 2'd0; decr_wid[1] = 2'd0;
    repeat (8) tick();
    clear_inputs();
    n_cmp++; if (empty_mask !== 4'hF || overflow !== 1'b1 || underflow !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got mask=%b ovf=%b unf=%b want 1111/1/1", empty_mask, overflow, underflow); end
    do_reset();
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL sat_reset_clear: got ovf=%b unf=%b want 0/0", overflow, underflow); end
  endtask

  task automatic test_fence_order();
    do_reset();
    incr = 1'b1; incr_wid[0] = 2'd0; tick();
    incr_wid[0] = 2'd3; tick();
    clear_inputs();
    fence_valid = 1'b1; fence_wid = 2'd0; #1;
    n_cmp++; if (fence_ready !== 1'b1) begin n_fail++; $display("FAIL fo_ready0: got %b want 1", fence_ready); end
    tick();
    fence_wid = 2'd3; #1;
    n_cmp++; if (fence_ready !== 1'b1) begin n_fail++; $display("FAIL fo_ready3: got %b want 1", fence_ready); end
    tick();
    fence_valid = 1'b0;
    tick();
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fo_busy: got done=%b want 0", fence_done); end
    decr = 2'b11; decr_wid[0] = 2'd0; decr_wid[1] = 2'd3;
    tick();
    clear_inputs();
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fo_drain_cycle: got done=%b want 0", fence_done); end
    tick();
    n_cmp++; if (fence_done !== 1'b1 || fence_done_wid !== 2'd0) begin n_fail++; $display("FAIL fo_first: got done=%b wid=%0d want 1/0", fence_done, fence_done_wid); end
    tick();
    n_cmp++; if (fence_done !== 1'b1 || fence_done_wid !== 2'd3) begin n_fail++; $display("FAIL fo_second: got done=%b wid=%0d want 1/3", fence_done, fence_done_wid); end
    tick();
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fo_after: got done=%b want 0", fence_done); end
    // Fence to an already-empty warp: done two cycles after acceptance.
    fence_valid = 1'b1; fence_wid = 2'd2;
    tick();
    clear_inputs();
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fo_empty_early: got done=%b want 0", fence_done); end
    tick();
    n_cmp++; if (fence_done !== 1'b1 || fence_done_wid !== 2'd2) begin n_fail++; $display("FAIL fo_empty_done: got done=%b wid=%0d want 1/2", fence_done, fence_done_wid); end
  endtask

  task automatic test_fence_stall_reset();
    do_reset();
    incr = 1'b1; incr_wid[0] = 2'd1;
    tick();
    clear_inputs();
    fence_valid = 1'b1; fence_wid = 2'd1;
    tick();
    n_cmp++; if (fence_ready !== 1'b0) begin n_fail++; $display("FAIL fs_stall: got ready=%b want 0", fence_ready); end
    tick();
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fs_no_done: got %b want 0", fence_done); end
    reset = 1'b0;
    tick();
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fs_rst_done_a: got %b want 0", fence_done); end
    tick();
    n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fs_rst_done_b: got %b want 0", fence_done); end
    reset = 1'b1;
    fence_valid = 1'b0; #1;
    n_cmp++; if (fence_ready !== 1'b1) begin n_fail++; $display("FAIL fs_ready_after: got %b want 1", fence_ready); end
    repeat (3) begin
      tick();
      n_cmp++; if (fence_done !== 1'b0) begin n_fail++; $display("FAIL fs_dropped: got done=%b want 0", fence_done); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset         = ($urandom_range(0, 99) != 0);
      incr          = IC'($urandom_range(0, 1));
      incr_wid[0]   = WW'($urandom);
      for (int p = 0; p < DC; p++) begin
        decr[p]     = ($urandom_range(0, 2) != 0);
        decr_wid[p] = WW'($urandom);
      end
      alm_thresh_we = ($urandom_range(0, 15) == 0);
      alm_thresh    = CW'($urandom_range(0, 3));
      alm_empty_wid = WW'($urandom);
      fence_valid   = ($urandom_range(0, 3) == 0);
      fence_wid     = WW'($urandom);
      #1;
      n_cmp++; if (fence_ready !== !m_pend[fence_wid]) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, fence_ready, !m_pend[fence_wid]); end
      tick();
      n_cmp++; if (empty_mask !== exp_mask()) begin n_fail++; $display("FAIL rnd_mask c=%0d: got %b want %b", c, empty_mask, exp_mask()); end
      n_cmp++; if (empty !== (&exp_mask())) begin n_fail++; $display("FAIL rnd_empty c=%0d: got %b want %b", c, empty, &exp_mask()); end
      n_cmp++; if (alm_empty !== (m_cnt[alm_empty_wid] == m_thresh)) begin n_fail++; $display("FAIL rnd_alm c=%0d: got %b want %b", c, alm_empty, m_cnt[alm_empty_wid] == m_thresh); end
      n_cmp++; if (overflow !== m_ovf || underflow !== m_unf) begin n_fail++; $display("FAIL rnd_sticky c=%0d: got %b%b want %b%b", c, overflow, underflow, m_ovf, m_unf); end
      n_cmp++; if (fence_done !== m_done) begin n_fail++; $display("FAIL rnd_done c=%0d: got %b want %b", c, fence_done, m_done); end
      if (m_done) begin
        n_cmp++; if (fence_done_wid !== m_done_wid) begin n_fail++; $display("FAIL rnd_done_wid c=%0d: got %0d want %0d", c, fence_done_wid, m_done_wid); end
      end
    end
    reset = 1'b1;
    clear_inputs();
  endtask

  initial begin
    reset         = 1'b0;
    alm_empty_wid = '0;
    clear_inputs();
    test_reset();
    test_count();
    test_alm();
    test_saturate();
    test_fence_order();
    test_fence_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_pending_tracker.md
VX_PENDING_TRACKER -- requirements
Module: VX_pending_tracker

Interface
REQ-001 SHALL have parameters: CTR_WIDTH=12 (per-warp counter width); WARP_CNT=`NUM_WARPS; WARP_CNT_WIDTH=`NW_WIDTH; INCR_COUNT=1 (issue ports); DECR_COUNT=2 (commit ports); ALM_EMPTY_DEF=1 (reset threshold).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports (name dir width meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset.
- incr  in  INCR_COUNT  per-port issue strobe.
- incr_wid  in  INCR_COUNT x WARP_CNT_WIDTH  warp id per issue port.
- decr  in  DECR_COUNT  per-port commit strobe.
- decr_wid  in  DECR_COUNT x WARP_CNT_WIDTH  warp id per commit port.
- alm_thresh_we  in  1  threshold write enable.
- alm_thresh  in  CTR_WIDTH  new almost-empty threshold.
- alm_empty_wid  in  WARP_CNT_WIDTH  warp selected for alm_empty.
- fence_valid  in  1  fence request.
- fence_wid  in  WARP_CNT_WIDTH  fence warp.
- fence_ready  out  1  fence accepted this cycle.
- fence_done  out  1  one-cycle fence completion pulse.
- fence_done_wid  out  WARP_CNT_WIDTH  completed warp.
- empty  out  1  all warps at zero.
- empty_mask  out  WARP_CNT  per-warp zero.
- alm_empty  out  1  selected warp count == threshold.
- overflow  out  1  sticky, increment attempted at max.
- underflow  out  1  sticky, decrement attempted at zero.

Function
REQ-004 Per warp w each cycle: inc_w = popcount of incr ports with incr_wid==w; dec_w = popcount of decr ports with decr_wid==w; computed in width clog2(max(INCR,DECR)+1)+1, signed delta.
REQ-005 Counter SHALL update at the clock edge of the strobe cycle: cnt_n = cnt + inc_w - dec_w, evaluated in CTR_WIDTH+2 signed arithmetic.
REQ-006 If cnt_n > 2^CTR_WIDTH-1, counter SHALL saturate at max and overflow SHALL set next cycle; if cnt_n < 0, counter SHALL clamp at 0 and underflow SHALL set; both are sticky until reset.
REQ-007 Simultaneous incr and decr to the same warp SHALL net (at zero with inc 1/dec 1: stays 0, no underflow).
REQ-008 empty_mask[w], alm-compare flags SHALL be registered from cnt_n, so they are valid the cycle after the strobe, same cycle as the counter.
REQ-009 empty = AND of empty_mask; alm_empty = (cnt[alm_empty_wid] == threshold), registered flag muxed combinationally by alm_empty_wid.
REQ-010 Threshold register: reset ALM_EMPTY_DEF; alm_thresh_we loads alm_thresh; compare uses new value from the next cycle.
REQ-011 Per-warp fence FSM, states IDLE, WAIT: IDLE->WAIT when fence_valid & fence_ready & fence_wid==w; WAIT->IDLE when granted completion.
REQ-012 fence_ready = (FSM[fence_wid]==IDLE), combinational; a request to a warp in WAIT SHALL stall (no loss, no duplicate).
REQ-013 A WAIT warp is eligible when empty_mask[w]==1 and no incr to w this cycle; eligible warps SHALL be granted one per cycle, lowest wid first; losers remain WAIT.
REQ-014 fence_done SHALL be a registered pulse one cycle after grant with fence_done_wid; fence accepted to an already-empty warp completes no earlier than 2 cycles after acceptance.
REQ-015 Fence state SHALL NOT block incr/decr; counting continues regardless.

Reset
REQ-016 While reset==0 at a clock edge: all counters 0, empty_mask all 1, empty=1, alm threshold=ALM_EMPTY_DEF, alm flags = (ALM_EMPTY_DEF==0), all FSMs IDLE, fence_done=0, overflow=underflow=0.
REQ-017 Reset mid-operation SHALL drop pending fences without emitting fence_done; strobes during reset SHALL be ignored.

Structure
REQ-018 Fence FSM state enum and popcount-width localparam SHALL reside in VX_gpu_pkg.
REQ-019 Per-warp counter+flags SHALL be one sub-module VX_pending_ctr (instantiated WARP_CNT times); fence arbitration uses the existing VX_priority_arbiter style fixed priority.

Verification
REQ-020 Reset, then incr w=2 for 3 cycles -> cnt[2]=3, empty_mask=4'b1011, empty=0; then 2-port decr w=2 single cycle + 1 more -> cnt=0, empty=1.
REQ-021 Threshold 1 default; cnt[1]=2, decr -> alm_empty=1 when alm_empty_wid=1; write alm_thresh=0 -> alm_empty=0 until cnt reaches 0.
REQ-022 CTR_WIDTH=4: 16 incr to w=0 -> cnt=15, overflow=1 sticky; decr at cnt=0 w=3 -> cnt stays 0, underflow=1.
REQ-023 cnt[0]=cnt[3]=1, fences on 0 and 3, decr both same cycle -> fence_done wid=0 then wid=3 on consecutive cycles.
REQ-024 Fence w=1 in WAIT, second fence w=1 -> fence_ready=0; reset asserted -> no fence_done, fence_ready=1 after release.
